// File: rtl/led_pkg.sv
// Shared types and constants for the LED scan stages.
package led_pkg;

  localparam logic [2:0] EN_ON  = 3'b100;
  localparam logic [2:0] EN_OFF = 3'b000;

  typedef logic [2:0] pos_t;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } scan_dir_e;

endpackage

// File: rtl/led_scan_seq_tick_prescaler.sv
// Free-running prescaler: tick is high on the cycle the count sits at TICK_DIV-1 with run=1.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q;
    tick      = 1'b0;
    if (run) begin
      if (div_cnt_q == LAST) begin
        div_cnt_d = '0;
        tick      = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_cnt_q <= '0;
    else      div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/led_scan_seq.sv
// LED scan sequencer driving the 3-to-8 decoder select/enable codes.
// Bounce mode is built only when LED_SCAN_SEQ_BOUNCE_EN is defined.
module led_scan_seq
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       dir,
  input  logic       mode,
  input  logic       blank,
  output logic [2:0] switch,
  output logic [2:0] enable,
  output logic       step,
  output logic       wrap
);

  logic tick;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .run (run),
    .tick(tick)
  );

  pos_t       pos_q, pos_d;
  logic [2:0] enable_q, enable_d;
  logic       step_q, step_d;
  logic       wrap_q, wrap_d;

`ifdef LED_SCAN_SEQ_BOUNCE_EN
  scan_dir_e state_q, state_d;
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  always_comb begin
    pos_d    = pos_q;
    step_d   = 1'b0;
    wrap_d   = 1'b0;
    enable_d = blank ? EN_OFF : EN_ON;
`ifdef LED_SCAN_SEQ_BOUNCE_EN
    state_d  = state_q;
    // In wrap mode the FSM shadows dir so a later switch to bounce keeps heading the same way.
    if (run && !mode) state_d = dir ? DIR_DOWN : DIR_UP;
`endif
    if (tick) begin
      step_d = 1'b1;
`ifdef LED_SCAN_SEQ_BOUNCE_EN
      if (mode) begin
        unique case (state_q)
          DIR_UP: begin
            if (pos_q == 3'd7) begin
              pos_d   = 3'd6;
              state_d = DIR_DOWN;
              wrap_d  = 1'b1;
            end else begin
              pos_d = pos_q + 3'd1;
            end
          end
          DIR_DOWN: begin
            if (pos_q == 3'd0) begin
              pos_d   = 3'd1;
              state_d = DIR_UP;
              wrap_d  = 1'b1;
            end else begin
              pos_d = pos_q - 3'd1;
            end
          end
          default: ;
        endcase
      end else
`endif
      if (dir) begin
        pos_d  = pos_q - 3'd1;
        wrap_d = (pos_q == 3'd0);
      end else begin
        pos_d  = pos_q + 3'd1;
        wrap_d = (pos_q == 3'd7);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_q    <= '0;
      enable_q <= EN_OFF;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      enable_q <= enable_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
    end
  end

`ifdef LED_SCAN_SEQ_BOUNCE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= DIR_UP;
    else      state_q <= state_d;
  end
`endif

  assign switch = pos_q;
  assign enable = enable_q;
  assign step   = step_q;
  assign wrap   = wrap_q;

endmodule
